// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the iterative restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// then subtract the divisor when the shifted partial remainder covers it.
module divider_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_div_ext;

  assign w_shift   = {i_rem, i_bit};
  assign w_div_ext = {2'b00, i_div};

  always_comb begin
    o_q   = (w_shift >= w_div_ext);
    o_rem = (WIDTH+1)'(o_q ? (w_shift - w_div_ext) : w_shift);
  end

endmodule

// File: rtl/divider.sv
// Free-running iterative restoring divider: LOAD, WIDTH CALC cycles, DONE.
// Optional done pulse output is enabled by defining DIVIDER_DONE_EN.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] number,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state;
  div_state_t       w_next;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_rem_next;
  logic             w_qbit;
  logic             w_load;
  logic             w_calc;
  logic             w_done;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_num[WIDTH-1]),
    .i_div (r_div),
    .o_rem (w_rem_next),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = CALC;
      CALC:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_calc = 1'b0;
    w_done = 1'b0;
    case (r_state)
      LOAD:    w_load = 1'b1;
      CALC:    w_calc = 1'b1;
      DONE:    w_done = 1'b1;
      default: w_load = 1'b0;
    endcase
  end

  // Dividend is consumed MSB first by shifting r_num left each CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num     <= '0;
      r_div     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (w_load) begin
        r_num <= number;
        r_div <= divisor;
        r_quo <= '0;
        r_rem <= '0;
        r_cnt <= CNT_W'(WIDTH - 1);
      end
      if (w_calc) begin
        r_num <= {r_num[WIDTH-2:0], 1'b0};
        r_rem <= w_rem_next;
        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done) begin
        quotient  <= r_quo;
        remainder <= WIDTH'(r_rem);
      end
    end
  end

`ifdef DIVIDER_DONE_EN
  logic r_done;

  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_done;
  end

  assign done = r_done;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_divider;

  localparam int unsigned W = 16;

  logic         clk     = 1'b0;
  logic         reset   = 1'b1;
  logic [W-1:0] number  = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIVIDER_DONE_EN
  logic         done;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;

  divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .number    (number),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DONE_EN
    ,
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    if (d == '0) begin
      q = '1;
      r = n;
    end else begin
      q = n / d;
      r = n % d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs must stay at the current expected pair for k cycles.
  task automatic hold(input int k, input string tag);
    bit bad = 1'b0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (quotient !== exp_q || remainder !== exp_r) bad = 1'b1;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Change operands at an arbitrary phase; outputs may only show old or new
  // result, never revert, and must show the new one within 36 cycles.
  task automatic apply(input logic [W-1:0] n, input logic [W-1:0] d, input string tag);
    logic [W-1:0] nq, nr, oq, orr;
    bit bad = 1'b0;
    bit seen_new = 1'b0;
    oq = exp_q;
    orr = exp_r;
    model(n, d, nq, nr);
    number  = n;
    divisor = d;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (quotient === nq && remainder === nr) seen_new = 1'b1;
      else if (quotient === oq && remainder === orr) begin
        if (seen_new) bad = 1'b1;
      end else bad = 1'b1;
    end
    chk({tag, " consistent"}, 32'(bad), 32'd0);
    chk({tag, " quotient"}, 32'(quotient), 32'(nq));
    chk({tag, " remainder"}, 32'(remainder), 32'(nr));
    exp_q = nq;
    exp_r = nr;
  endtask

  // Deassert reset with new operands: outputs stay zero for 17 edges and the
  // result appears exactly on the 18th edge.
  task automatic release_check(input logic [W-1:0] n, input logic [W-1:0] d, input string tag);
    logic [W-1:0] nq, nr;
    bit bad = 1'b0;
    model(n, d, nq, nr);
    reset   = 1'b0;
    number  = n;
    divisor = d;
    for (int i = 1; i < 18; i++) begin
      tick();
      if (quotient !== '0 || remainder !== '0) bad = 1'b1;
`ifdef DIVIDER_DONE_EN
      if (done !== 1'b0) bad = 1'b1;
`endif
    end
    chk({tag, " zero before result"}, 32'(bad), 32'd0);
    tick();
    chk({tag, " quotient at 18"}, 32'(quotient), 32'(nq));
    chk({tag, " remainder at 18"}, 32'(remainder), 32'(nr));
`ifdef DIVIDER_DONE_EN
    chk({tag, " done at 18"}, 32'(done), 32'd1);
`endif
    exp_q = nq;
    exp_r = nr;
  endtask

  initial begin
    logic [W-1:0] rn, rd;

    reset = 1'b1;
    number  = 16'd9;
    divisor = 16'd1;
    repeat (3) tick();
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
`ifdef DIVIDER_DONE_EN
    chk("reset done", 32'(done), 32'd0);
`endif
    exp_q = '0;
    exp_r = '0;

    release_check(16'd9, 16'd1, "9/1");
    hold(40, "9/1 stable");

    apply(16'd6, 16'd2, "6/2");
    apply(16'd8, 16'd5, "8/5");
    apply(16'd7, 16'd0, "7/0");
    apply(16'd65535, 16'd1, "65535/1");
    apply(16'd3, 16'd10, "3/10");
    apply(16'd65535, 16'd65535, "max/max");
    apply(16'd0, 16'd0, "0/0");
    apply(16'd0, 16'd5, "0/5");
    apply(16'd65535, 16'd0, "max/0");

    for (int t = 0; t < 25; t++) begin
      hold($urandom_range(1, 17), "random idle hold");
      rn = W'($urandom);
      case ($urandom_range(0, 3))
        0: rd = '0;
        1: begin
          rn = W'($urandom_range(0, 999));
          rd = W'($urandom_range(1000, 65535));
        end
        2: rd = W'($urandom_range(1, 15));
        default: rd = W'($urandom);
      endcase
      apply(rn, rd, "random");
    end

    // Reset mid-CALC aborts the division and clears the outputs.
    reset = 1'b1;
    tick();
    release_check(16'd100, 16'd7, "100/7");
    number  = 16'd50000;
    divisor = 16'd3;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mid-calc reset quotient", 32'(quotient), 32'd0);
    chk("mid-calc reset remainder", 32'(remainder), 32'd0);
`ifdef DIVIDER_DONE_EN
    chk("mid-calc reset done", 32'(done), 32'd0);
`endif
    release_check(16'd50000, 16'd3, "50000/3");

`ifdef DIVIDER_DONE_EN
    begin
      int pulses = 0;
      int last = 0;
      bit bad = 1'b0;
      logic [W-1:0] pq, pr;
      pq = quotient;
      pr = remainder;
      for (int i = 1; i <= 180; i++) begin
        if (i % 7 == 0) begin
          number  = W'($urandom);
          divisor = W'($urandom_range(1, 300));
        end
        tick();
        if (done === 1'b1) begin
          pulses++;
          if (i - last != 18) bad = 1'b1;
          last = i;
        end else if (quotient !== pq || remainder !== pr) bad = 1'b1;
        pq = quotient;
        pr = remainder;
      end
      chk("done pulse count", 32'(pulses), 32'd10);
      chk("done spacing and output alignment", 32'(bad), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 2..32.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port number, input, WIDTH bits: unsigned dividend.
REQ-005 Port divisor, input, WIDTH bits: unsigned divisor.
REQ-006 Port quotient, output, WIDTH bits: registered unsigned quotient of the last completed division.
REQ-007 Port remainder, output, WIDTH bits: registered unsigned remainder of the last completed division.
REQ-008 Ports are ordered clk, reset, number, divisor, quotient, remainder, so that positional instantiation works.

Function
REQ-009 The block SHALL be a free-running iterative restoring divider with no start/valid handshake; it recomputes continuously from the current inputs.
REQ-010 FSM states SHALL be LOAD, CALC and DONE.
REQ-011 LOAD (1 cycle): latch number and divisor into internal operand registers, clear the partial remainder, set the bit counter to WIDTH-1, then go to CALC.
REQ-012 CALC (WIDTH cycles): each cycle, shift the next dividend bit (MSB first) into the partial remainder; if partial remainder >= divisor, subtract it and set the quotient bit to 1, else set the quotient bit to 0. After the bit-0 cycle, go to DONE.
REQ-013 DONE (1 cycle): load quotient and remainder outputs from the working registers, then go to LOAD.
REQ-014 Iteration period SHALL be WIDTH+2 cycles (18 for WIDTH=16).
REQ-015 Worst-case latency from an input change to the correct outputs SHALL be 2*(WIDTH+2) cycles (36 for WIDTH=16).
REQ-016 Input changes during CALC or DONE SHALL be ignored until the next LOAD; the outputs always describe one consistent latched operand pair.
REQ-017 Outputs SHALL change only in DONE and hold their value at all other times.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide so that compare and subtract never overflow.
REQ-019 For divisor = 0, the result SHALL be quotient = all ones and remainder = number; the FSM timing is unchanged.
REQ-020 For number < divisor, the result SHALL be quotient = 0 and remainder = number.

Reset
REQ-021 While reset = 1 at a clock edge: quotient = 0, remainder = 0, all working registers = 0, state = LOAD.
REQ-022 Reset asserted mid-CALC SHALL abort the division; no partial result reaches the outputs.
REQ-023 On the first edge after reset deasserts, the block SHALL perform a LOAD.

Configuration
REQ-024 When macro DIVIDER_DONE_EN is defined, the block SHALL add an output port done (1 bit, after remainder), which is high for exactly the one cycle after the outputs update (registered from DONE) and is 0 in reset.
REQ-025 Without DIVIDER_DONE_EN, the done port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package divider_pkg SHALL hold the DIV_WIDTH_DEFAULT = 16 constant and the state enum typedef div_state_t {LOAD, CALC, DONE}.
REQ-027 Sub-module divider_step SHALL implement one combinational restoring iteration:
- inputs: partial remainder, dividend bit, divisor;
- outputs: next partial remainder, quotient bit.
REQ-028 The divider top SHALL instantiate divider_step once and hold the FSM, counter and registers.

Verification
REQ-029 Reset, then number=9, divisor=1 -> within 36 cycles quotient=9, remainder=0, stable thereafter.
REQ-030 Change to number=6, divisor=2 -> within 36 cycles quotient=3, remainder=0.
REQ-031 Change to number=8, divisor=5 -> within 36 cycles quotient=1, remainder=3.
REQ-032 number=7, divisor=0 -> quotient=16'hFFFF, remainder=7; number=65535, divisor=1 -> quotient=65535, remainder=0.
REQ-033 Assert reset for 1 cycle mid-CALC -> next cycle quotient=0, remainder=0; a correct result follows 18 cycles after deassertion.
REQ-034 With DIVIDER_DONE_EN defined, done pulses exactly once every 18 cycles, coincident with the output update.
